// File: rtl/pb_cmd_arbiter.sv
// pb_cmd_arbiter: collects one-cycle press pulses from N_PB debouncers,
// latches them, arbitrates round-robin and queues the winning button IDs
// in a small first-word-fall-through FIFO for the test-sequence controller.
// Presses that arrive while their button is still waiting are counted as
// drops in a saturating counter.
module pb_cmd_arbiter #(
  parameter int N_PB  = 4,
  parameter int ID_W  = 2,
  parameter int DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [N_PB-1:0] i_pb_down,
  input  logic            i_cmd_ready,
  output logic            o_cmd_valid,
  output logic [ID_W-1:0] o_cmd_id,
  output logic [7:0]      o_drop_count,
  output logic [7:0]      o_debug
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Reset release synchroniser. Assertion clears the block immediately;
  // release reaches the state flops two edges later, aligned to i_clk.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Shift a one into the synchroniser after i_reset is released.
  always_ff @(posedge i_clk or negedge i_reset) begin
    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of process order.
    if (!i_reset) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // State
  logic [N_PB-1:0]  pending_q,    pending_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [PTR_W-1:0] wr_ptr_q,     wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,     rd_ptr_d;
  logic [CNT_W-1:0] count_q,      count_d;
  logic [7:0]       drop_count_q, drop_count_d;
  logic             drop_flag_q,  drop_flag_d;
  logic [ID_W-1:0]  mem_q [DEPTH];

  // Combinational helpers
  logic             fifo_has_room;
  logic             grant_valid;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  cand;
  logic             drop_any;
  logic             push;
  logic             pop;
  logic [3:0]       debug_pend;
  logic [2:0]       debug_cnt;

  // The full check uses the registered count only, so a pop in the same
  // cycle never makes room for a push.
  assign fifo_has_room = (count_q < CNT_W'(DEPTH));

  // Round-robin search over registered pending, starting just above the
  // last granted index and wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update,
    // otherwise paths that skip the assignment would infer latches.
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (fifo_has_room) begin
      for (int off = 1; off <= N_PB; off++) begin
        cand = ID_W'((int'(last_grant_q) + off) % N_PB);
        if (!grant_valid && pending_q[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  // Pending latch update and drop detection. A press on a bit that is
  // being granted this cycle is kept; a press on a bit still waiting is lost.
  always_comb begin
    pending_d = pending_q;
    drop_any  = 1'b0;
    for (int k = 0; k < N_PB; k++) begin
      if (i_pb_down[k]) begin
        pending_d[k] = 1'b1;
        if (pending_q[k] && !(grant_valid && grant_idx == ID_W'(k))) drop_any = 1'b1;
      end else if (grant_valid && grant_idx == ID_W'(k)) begin
        pending_d[k] = 1'b0;
      end
    end
  end

  assign push        = grant_valid;
  assign o_cmd_valid = (count_q != '0);
  assign pop         = o_cmd_valid && i_cmd_ready;

  // FIFO pointers, count, arbiter history and drop statistics.
  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    last_grant_d = push ? grant_idx : last_grant_q;
    count_d      = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    drop_count_d = (drop_any && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;
    drop_flag_d  = drop_flag_q | drop_any;
  end

  // Control state register; cleared as a whole by reset.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      last_grant_q <= ID_W'(N_PB - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_count_q <= '0;
      drop_flag_q  <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_count_q <= drop_count_d;
      drop_flag_q  <= drop_flag_d;
    end
  end

  // FIFO storage write.
  always_ff @(posedge i_clk) begin
    // NOTE: storage has no reset; entries are only visible through the
    // count, and the head output is forced to zero while empty.
    if (push) mem_q[wr_ptr_q] <= grant_idx;
  end

  assign o_cmd_id     = o_cmd_valid ? mem_q[rd_ptr_q] : '0;
  assign o_drop_count = drop_count_q;

  // Debug fields, zero-padded when fewer than four buttons or a narrow count.
  always_comb begin
    debug_pend = '0;
    debug_cnt  = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < N_PB) debug_pend[k] = pending_q[k];
    end
    for (int k = 0; k < 3; k++) begin
      if (k < CNT_W) debug_cnt[k] = count_q[k];
    end
  end

  assign o_debug = {debug_pend, debug_cnt, drop_flag_q};

endmodule

// File: doc/pb_cmd_arbiter.md
# pb_cmd_arbiter

Collects debounced push-button press events from `N_PB` debouncer instances and serialises them into one ordered stream of button-ID commands for the SRAM test controller. Simultaneous or overlapping presses are arbitrated round-robin, buffered in a small first-word-fall-through FIFO, and presented on a valid/ready interface. Presses that cannot be recorded are counted. The block sits between the per-button debouncers' down-pulse outputs and the test-sequence controller.

## Interface
- `N_PB`, 4: number of buttons; 2..8.
- `ID_W`, 2: width of the command ID; must satisfy 2^ID_W ≥ N_PB.
- `DEPTH`, 4: FIFO entries; power of 2, ≥ 2.
- `i_clk`  in  1  single system clock; all logic on rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_pb_down`  in  N_PB  one-cycle press pulses; bit k comes from debouncer k.
- `i_cmd_ready`  in  1  consumer accepts the current command.
- `o_cmd_valid`  out  1  FIFO non-empty.
- `o_cmd_id`  out  ID_W  button index at the FIFO head; 0 when empty.
- `o_drop_count`  out  8  saturating count of lost presses.
- `o_debug`  out  8  [7:4] = pending[3:0] (zero-padded/truncated), [3:1] = FIFO count[2:0], [0] = sticky drop flag.

## Operation
- **Pending latches, `pending[N_PB-1:0]`**
  - Bit k sets on `i_pb_down[k]`.
  - Bit k clears when button k is granted.
  - Press and grant of the same bit in the same cycle: the bit stays set, and the new press is kept.
  - Press on a bit that is already set and not granted that cycle: the press is dropped; `o_drop_count` increments and saturates at 255; the sticky flag sets.
  - Presses on several bits in one cycle are handled independently, but at most one drop increment per cycle; excess drops in that cycle are not counted.
- **Arbiter**
  - Each cycle in which pending ≠ 0 and the FIFO is not full (registered count < DEPTH), exactly one index is granted.
  - Search starts at `(last_grant+1) mod N_PB` and proceeds upward with wrap.
  - The granted index is written into the FIFO and `last_grant` is updated.
  - The arbiter works only on registered pending, so a pulse is never granted in its own arrival cycle.
- **FIFO**
  - First-word-fall-through: `o_cmd_id` = `mem[rd_ptr]` when non-empty.
  - Pop when `o_cmd_valid && i_cmd_ready`.
  - Push and pop in the same cycle are allowed: count unchanged, both pointers advance.
  - No push is attempted when count = DEPTH, even if a pop occurs that cycle. The full check uses the registered count.
  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- **States.** The block has no explicit FSM. Behaviour is determined by pending, `last_grant`, and FIFO count (empty / partial / full).
- **Reset (asynchronous assert, synchronous release)**
  - pending = 0.
  - `last_grant` = N_PB−1, so index 0 has first priority.
  - Pointers = 0, count = 0.
  - `o_cmd_valid` = 0, `o_cmd_id` = 0, `o_drop_count` = 0, `o_debug` = 0.
  - Reset mid-operation discards all pending and queued commands.

## Timing
- Press pulse in cycle T → pending set at the edge ending T → granted and pushed at the edge ending T+1 → `o_cmd_valid` = 1 in cycle T+2 if the FIFO was empty.
- Throughput: one grant per cycle and one pop per cycle. N simultaneous presses drain in N consecutive cycles when ready is held high.
- `o_cmd_valid` and `o_cmd_id` are registered-state outputs with no combinational path from `i_cmd_ready`.
- Once asserted, `o_cmd_valid` stays high and `o_cmd_id` stays stable until the pop.

## Test plan
- **Reset values.** Hold `i_reset` = 0 for 10 cycles, pulsing `i_pb_down` = 4'hF during reset → all outputs 0. Release → `o_cmd_valid` stays 0, so no press is captured during reset.
- **Single press latency.** `i_cmd_ready` = 1; pulse bit 2 in cycle T → `o_cmd_valid` = 1 with `o_cmd_id` = 2 in cycle T+2 only, then 0.
- **Round-robin ordering.** `i_cmd_ready` = 1.
  - Pulse 4'b1011 → ids 0, 1, 3 on consecutive cycles.
  - Then pulse 4'b1111 → ids 0, 1, 2, 3.
  - Then pulse 4'b0110 after a grant of 1 → ids 2, 1.
- **Full FIFO, backpressure and drop count.** `i_cmd_ready` = 0.
  - Pulse bits 0, 1, 2, 3 once each → count = 4, `o_debug[3:1]` = 4.
  - Pulse bit 0 → pending[0] = 1, held.
  - Pulse bit 0 again → `o_drop_count` = 1, `o_debug[0]` = 1.
  - Raise ready → ids 0, 1, 2, 3, 0, then `o_cmd_valid` = 0.
- **Saturation.** Keep pending[1] set with the FIFO full; pulse bit 1 on 300 cycles → `o_drop_count` = 255.
- **Reset mid-operation.** With 3 entries queued and pending = 4'b0100, assert `i_reset` asynchronously between edges → `o_cmd_valid` = 0 immediately. After release, a bit-3 pulse yields id 3 first, proving the queue and pending were flushed.
